// File: rtl/debug_slave.sv
// rtl/debug_slave.sv - debug register slave driving CPU run control, register file and memory
// Host writes CMD/ADDRESS/DATA, raises req, and waits for a single ack pulse.
module debug_slave (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_write_data,
  input  logic        i_wr_en,
  input  logic        i_req,
  output logic        o_ack,
  output logic [31:0] o_read_data,
  output logic        o_halt_req,
  output logic        o_run_req,
  output logic        o_step_req,
  input  logic        i_cpu_halted,
  output logic [3:0]  o_reg_sel,
  output logic [31:0] o_reg_wr_val,
  output logic        o_reg_wr_en,
  input  logic [31:0] i_reg_rd_val,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wr_data,
  output logic        o_mem_wr_en,
  output logic        o_mem_access,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_ack
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_EXEC      = 3'd1;
  localparam logic [2:0] S_HALT_WAIT = 3'd2;
  localparam logic [2:0] S_STEP_WAIT = 3'd3;
  localparam logic [2:0] S_MEM_WAIT  = 3'd4;
  localparam logic [2:0] S_ACK       = 3'd5;

  localparam logic [3:0] C_HALT   = 4'd0;
  localparam logic [3:0] C_RUN    = 4'd1;
  localparam logic [3:0] C_STEP   = 4'd2;
  localparam logic [3:0] C_RD_REG = 4'd3;
  localparam logic [3:0] C_WR_REG = 4'd4;
  localparam logic [3:0] C_RD_MEM = 4'd5;
  localparam logic [3:0] C_WR_MEM = 4'd6;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [3:0]  r_cmd;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_err;
  logic        r_step_seen;
  logic        r_ack_d;
  logic        w_busy;
  logic        w_start;
  logic        w_live;
  logic        w_exec;
  logic        w_needs_halt;
  logic        w_mem_access;

  assign w_busy       = (r_state != S_IDLE);
  // r_ack_d masks req in the cycle after ack so a still-high req is not re-taken
  assign w_start      = (r_state == S_IDLE) && i_req && !r_ack_d;
  assign w_live       = !i_rst;
  assign w_exec       = w_live && (r_state == S_EXEC);
  assign w_needs_halt = (r_cmd == C_STEP) || (r_cmd == C_RD_REG) || (r_cmd == C_WR_REG);
  assign w_mem_access = w_live && (r_state == S_MEM_WAIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_start) w_next = S_EXEC;
      S_EXEC: begin
        case (r_cmd)
          C_HALT:             w_next = i_cpu_halted ? S_ACK : S_HALT_WAIT;
          C_STEP:             w_next = i_cpu_halted ? S_STEP_WAIT : S_ACK;
          C_RD_MEM, C_WR_MEM: w_next = S_MEM_WAIT;
          default:            w_next = S_ACK;
        endcase
      end
      S_HALT_WAIT: if (i_cpu_halted) w_next = S_ACK;
      S_STEP_WAIT: if (r_step_seen && i_cpu_halted) w_next = S_ACK;
      S_MEM_WAIT:  if (i_mem_ack) w_next = S_ACK;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cmd       <= 4'd0;
      r_addr      <= 32'd0;
      r_data      <= 32'd0;
      r_err       <= 1'b0;
      r_step_seen <= 1'b0;
      r_ack_d     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ack_d     <= (r_state == S_ACK);
      // halted must be observed at least two cycles after the step pulse
      r_step_seen <= (r_state == S_STEP_WAIT);
      if (i_wr_en && !w_busy) begin
        case (i_addr)
          2'd0:    r_cmd  <= i_write_data[3:0];
          2'd1:    r_addr <= i_write_data;
          2'd2:    r_data <= i_write_data;
          default: ;
        endcase
      end
      if (w_start) r_err <= 1'b0;
      if (r_state == S_EXEC) begin
        if (w_needs_halt && !i_cpu_halted) r_err <= 1'b1;
        if ((r_cmd == C_RD_REG) && i_cpu_halted) r_data <= i_reg_rd_val;
      end
      if ((r_state == S_MEM_WAIT) && i_mem_ack && (r_cmd == C_RD_MEM)) r_data <= i_mem_rd_data;
    end
  end

  always_comb begin
    o_read_data = 32'd0;
    case (i_addr)
      2'd0:    o_read_data = {28'b0, r_cmd};
      2'd1:    o_read_data = r_addr;
      2'd2:    o_read_data = r_data;
      default: o_read_data = {29'b0, r_err, w_busy, i_cpu_halted};
    endcase
  end

  // every output is held low while reset is asserted
  assign o_ack         = w_live && (r_state == S_ACK);
  assign o_halt_req    = w_exec && (r_cmd == C_HALT) && !i_cpu_halted;
  assign o_run_req     = w_exec && (r_cmd == C_RUN);
  assign o_step_req    = w_exec && (r_cmd == C_STEP) && i_cpu_halted;
  assign o_reg_wr_en   = w_exec && (r_cmd == C_WR_REG) && i_cpu_halted;
  assign o_reg_sel     = {4{w_live}} & r_addr[3:0];
  assign o_reg_wr_val  = {32{w_live}} & r_data;
  assign o_mem_addr    = {32{w_live}} & r_addr;
  assign o_mem_wr_data = {32{w_live}} & r_data;
  assign o_mem_access  = w_mem_access;
  assign o_mem_wr_en   = w_mem_access && (r_cmd == C_WR_MEM);

endmodule

// File: doc/debug_slave.md
DEBUG_SLAVE -- requirements
Module: debug_slave

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 addr  input  2  debug register select: 0 CMD, 1 ADDRESS, 2 DATA, 3 STATUS.
REQ-004 write_data  input  32  value written to the selected register.
REQ-005 wr_en  input  1  write strobe; writes the selected register on a clk edge where wr_en=1.
REQ-006 req  input  1  command request; held high until ack is seen.
REQ-007 ack  output  1  one-cycle completion pulse for a command.
REQ-008 read_data  output  32  contents of the selected register.
REQ-009 halt_req, run_req, step_req  output  1 each  one-cycle pulses to the CPU.
REQ-010 cpu_halted  input  1  CPU is stopped.
REQ-011 reg_sel  output  4 ; reg_wr_val  output  32 ; reg_wr_en  output  1 ; reg_rd_val  input  32  register file port.
REQ-012 mem_addr  output  32 ; mem_wr_data  output  32 ; mem_wr_en  output  1 ; mem_access  output  1 ; mem_rd_data  input  32 ; mem_ack  input  1  memory port.

Function
REQ-013 read_data SHALL be combinational from addr: 0 -> {28'b0, cmd}; 1 -> ADDRESS; 2 -> DATA; 3 -> {29'b0, err, busy, cpu_halted}.
REQ-014 A wr_en write SHALL update CMD (write_data[3:0]), ADDRESS or DATA on that edge; a write to STATUS SHALL be ignored; writes while busy=1 SHALL be ignored.
REQ-015 CMD codes: 0 HALT, 1 RUN, 2 STEP, 3 READ_REG, 4 WRITE_REG, 5 READ_MEM, 6 WRITE_MEM; codes 7-15 are NOP.
REQ-016 FSM states: IDLE, HALT_WAIT, STEP_WAIT, MEM_WAIT, ACK; busy=1 in every state except IDLE.
REQ-017 IDLE: when req=1, execute CMD and leave IDLE; otherwise remain in IDLE.
REQ-018 HALT: pulse halt_req in the first cycle; go to HALT_WAIT; advance to ACK on the first cycle cpu_halted=1; if cpu_halted=1 at entry, go directly to ACK with no pulse.
REQ-019 RUN: pulse run_req in the first cycle; go to ACK.
REQ-020 STEP: if cpu_halted=0, set err and go to ACK; otherwise pulse step_req, go to STEP_WAIT, and advance to ACK when cpu_halted=1 two or more cycles after the pulse.
REQ-021 READ_REG / WRITE_REG: require cpu_halted=1, otherwise set err and go to ACK with no access; reg_sel = ADDRESS[3:0]; READ latches reg_rd_val into DATA; WRITE drives reg_wr_val=DATA and pulses reg_wr_en for 1 cycle; then go to ACK.
REQ-022 READ_MEM / WRITE_MEM: drive mem_addr=ADDRESS, mem_wr_data=DATA, mem_wr_en=(WRITE_MEM), and mem_access=1 in MEM_WAIT until the cycle mem_ack=1; READ latches mem_rd_data into DATA in that cycle; then go to ACK; memory accesses are allowed with the CPU running.
REQ-023 NOP: go directly to ACK.
REQ-024 ACK: ack=1 for exactly one cycle, then IDLE; req is ignored in the ACK cycle and the cycle after it, so one req assertion yields exactly one command.
REQ-025 err SHALL clear at the start of each new command and persist until then.
REQ-026 Latency from req sampled high to ack: RUN/NOP/REG = 2 cycles; MEM = 2 + wait cycles; HALT/STEP depend on cpu_halted.
REQ-027 halt_req, run_req, step_req, reg_wr_en and mem_access SHALL be 0 in every state where they are not specified above.

Reset
REQ-028 rst SHALL force IDLE and set CMD=0, ADDRESS=0, DATA=0 and err=0.
REQ-029 While rst=1, all outputs SHALL be 0 except read_data, which follows REQ-013.
REQ-030 rst asserted mid-command SHALL abort the command: no ack, mem_access drops on the next edge, and there is no CPU side effect after reset.

Verification
REQ-031 cpu_halted=0; write CMD=0; req=1; CPU raises cpu_halted 5 cycles after halt_req -> one halt_req pulse; ack 1 cycle after cpu_halted rises; STATUS reads 0x1.
REQ-032 Halted; write ADDRESS=3, CMD=3; reg_rd_val=0xDEADBEEF; req -> reg_sel=3; ack on 2nd cycle; DATA reads 0xDEADBEEF.
REQ-033 Write ADDRESS=0x1000, DATA=0x12345678, CMD=6; mem_ack delayed 4 cycles -> mem_access=1 and mem_wr_en=1 for 4 cycles with correct addr/data; single ack; DATA unchanged.
REQ-034 cpu_halted=0; CMD=4; req -> no reg_wr_en; ack after 2 cycles; STATUS reads 0x4; next NOP command clears err.
REQ-035 Start READ_MEM; assert rst while in MEM_WAIT -> mem_access=0 next edge, no ack, all registers zero.
REQ-036 Write DATA while busy -> DATA unchanged; req held through ack -> exactly one command executed.
